// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word read outstanding to instruction memory,
// and buffers returned words in a small FIFO that decode drains with a valid/ready handshake.
//
//  state     | meaning
//  S_IDLE    | no read outstanding; waiting for buffer space or a redirect
//  S_REQ     | read outstanding at imem_addr; returned word is kept
//  S_DISCARD | read outstanding at a stale PC; returned word is dropped, then fetch at target_q
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     target_q, target_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_q    [FIFO_DEPTH];

  logic [31:0]     tgt_aligned;
  logic            push, pop;
  logic [CW-1:0]   count_pop;
  logic            unused_tgt_bits;

  assign tgt_aligned     = {branch_target[31:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  assign imem_req    = (state_q != S_IDLE);
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];

  // A redirect flushes the buffer, so any pop in the same cycle is meaningless.
  assign pop       = instr_valid & instr_ready & ~branch_en;
  assign push      = (state_q == S_REQ) & imem_ack & ~branch_en;
  assign count_pop = count_q - CW'(pop);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    target_d = target_q;
    unique case (state_q)
      S_IDLE: begin
        if (branch_en) begin
          addr_d  = tgt_aligned;
          state_d = S_REQ;
        end else if (count_pop < CW'(FIFO_DEPTH)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (branch_en) begin
            addr_d = tgt_aligned;
          end else begin
            addr_d = addr_q + 32'd4;
            if (count_pop + CW'(1) >= CW'(FIFO_DEPTH)) state_d = S_IDLE;
          end
        end else if (branch_en) begin
          target_d = tgt_aligned;
          state_d  = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (branch_en) target_d = tgt_aligned;
        if (imem_ack) begin
          addr_d  = branch_en ? tgt_aligned : target_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (branch_en) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= addr_q;
      end
    end
  end

  ack_only_when_requested: assert property (@(posedge clk) disable iff (rst) imem_ack |-> imem_req);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model compared every cycle, directed scenarios
// with literal expectations, then randomized traffic with redirects and resets.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr, instr_pc;
  logic [5:0]  opcode, funct;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  // reference model: buffered {pc, word} entries plus the outstanding-read bookkeeping
  logic [63:0] mq[$];
  bit          m_req  = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_next = RESET_PC;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return 32'h8C00_0000 + a;
  endfunction

  task automatic model_update();
    logic [31:0] tgt;
    tgt = {branch_target[31:2], 2'b00};
    if (rst) begin
      mq.delete();
      m_req  = 1'b0;
      m_drop = 1'b0;
      m_addr = RESET_PC;
    end else begin
      if (branch_en) mq.delete();
      else if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
      if (m_req) begin
        if (imem_ack) begin
          if (m_drop || branch_en) begin
            m_addr = branch_en ? tgt : m_next;
            m_drop = 1'b0;
          end else begin
            mq.push_back({m_addr, imem_rdata});
            m_addr = m_addr + 32'd4;
            m_req  = (mq.size() < DEPTH);
          end
        end else if (branch_en) begin
          m_drop = 1'b1;
          m_next = tgt;
        end
      end else if (branch_en) begin
        m_addr = tgt;
        m_req  = 1'b1;
      end else begin
        m_req = (mq.size() < DEPTH);
      end
    end
  endtask

  task automatic compare();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0 && instr_valid) begin
      chk("instr", instr, mq[0][31:0]);
      chk("instr_pc", instr_pc, mq[0][63:32]);
      chk("opcode", {26'd0, opcode}, {26'd0, mq[0][31:26]});
      chk("funct", {26'd0, funct}, {26'd0, mq[0][5:0]});
    end
  endtask

  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic b, input logic [31:0] t, input logic rdy);
    rst = r; imem_ack = a; imem_rdata = d;
    branch_en = b; branch_target = t; instr_ready = rdy;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;

    // reset state
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // streaming: ack every cycle, decode always ready
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("t1_first_req", {31'd0, imem_req}, 32'd1);
    chk("t1_first_addr", imem_addr, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      a = 32'(4 * (k - 1));
      step(1'b0, 1'b1, word_for(a), 1'b0, '0, 1'b1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_pc", instr_pc, a);
      chk("t1_opcode", {26'd0, opcode}, 32'h23);
    end

    // back-pressure fills the buffer, then one pop restarts fetch at 8
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, word_for(32'h0), 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, word_for(32'h4), 1'b0, '0, 1'b0);
    chk("t2_req_dropped", {31'd0, imem_req}, 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("t2_still_idle", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h8);
    chk("t2_second_pc", instr_pc, 32'h4);

    // redirect while a read is outstanding: old read completes and is dropped
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 32'h10, 1'b1);
    chk("t3_req_at_10", imem_addr, 32'h10);
    step(1'b0, 1'b0, '0, 1'b1, 32'h103, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("t3_addr_held", imem_addr, 32'h10);
    chk("t3_req_held", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b1, word_for(32'h10), 1'b0, '0, 1'b1);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_dropped", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b1, word_for(32'h100), 1'b0, '0, 1'b1);
    chk("t3_first_pc", instr_pc, 32'h100);

    // redirect coincident with an ack flushes the buffer and drops the acked word
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, word_for(32'h0), 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, word_for(32'h4), 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, word_for(32'h8), 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, word_for(32'hC), 1'b1, 32'h40, 1'b1);
    chk("t4_flushed", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", imem_addr, 32'h40);
    step(1'b0, 1'b1, word_for(32'h40), 1'b0, '0, 1'b1);
    chk("t4_first_pc", instr_pc, 32'h40);

    // PC wrap
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    chk("t5_addr0", imem_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b1, word_for(32'hFFFF_FFF8), 1'b0, '0, 1'b1);
    chk("t5_addr1", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, word_for(32'hFFFF_FFFC), 1'b0, '0, 1'b1);
    chk("t5_addr2", imem_addr, 32'h0000_0000);

    // reset during an outstanding read
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_addr", imem_addr, RESET_PC);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, b, ak, rdy;
      logic [31:0] t;
      r   = ($urandom_range(0, 199) == 0);
      b   = ($urandom_range(0, 15) == 0);
      t   = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      ak  = m_req && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 9) < 7);
      step(r, ak, $urandom, b, t, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
